// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snake_dir_ctrl
// Brief    : Buffers legal button direction requests in a small FIFO and
//            commits one as the snake heading on each unpaused move tick.
// Revision : 1.0
// ============================================================================
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 4,
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  button_pulse,
    input  logic                        move_tick,
    input  logic                        pause,
    output logic [1:0]                  dir,
    output logic                        dir_upd,
    output logic [$clog2(QDEPTH):0]     q_count,
    output logic                        q_full,
    output logic                        drop
);

    localparam int c_AW = $clog2(QDEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(QDEPTH);

    logic [1:0]      r_mem [QDEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [1:0]      r_dir;
    logic            r_dir_upd;
    logic            r_full;
    logic            r_drop;

    logic            w_req_valid;
    logic [1:0]      w_req_dir;
    logic [1:0]      w_ref;
    logic [c_AW-1:0] w_last_ptr;
    logic            w_reject;
    logic            w_push;
    logic            w_pop;
    logic [c_CW-1:0] w_count_nxt;

    // Lowest set bit wins; its index is the direction code.
    always_comb begin
        w_req_dir = 2'b11;
        if (button_pulse[0])      w_req_dir = 2'b00;
        else if (button_pulse[1]) w_req_dir = 2'b01;
        else if (button_pulse[2]) w_req_dir = 2'b10;
    end

    assign w_req_valid = |button_pulse;
    assign w_last_ptr  = r_wptr - 1'b1;
    assign w_ref       = (r_count != '0) ? r_mem[w_last_ptr] : r_dir;

    // Compare against the newest pending heading so queued moves never fold back.
    assign w_reject = (w_req_dir == w_ref) || (w_req_dir == (w_ref ^ 2'b01)) || (r_count == c_DEPTH);
    assign w_push   = w_req_valid && !w_reject;
    assign w_pop    = move_tick && !pause && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= w_req_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_dir     <= INIT_DIR;
            r_dir_upd <= 1'b0;
            r_full    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_full    <= (w_count_nxt == c_DEPTH);
            r_drop    <= w_req_valid && w_reject;
            r_dir_upd <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_dir  <= r_mem[r_rptr];
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign dir     = r_dir;
    assign dir_upd = r_dir_upd;
    assign q_count = r_count;
    assign q_full  = r_full;
    assign drop    = r_drop;

endmodule
`default_nettype wire
